pixel_frame_writer: RTL and testbench
=====================================

Name: pixel_frame_writer

Overview:
- Downstream of the game top-level draw sequencer. Consumes its per-cycle pixel stream (x, y, colour, write enable) and commits it to the 160x120, 3-bit framebuffer RAM write port.
- Decouples the sequencer from the RAM with a small FIFO.
- Discards off-screen coordinates and counts them.
- Provides a full-screen clear engine, so the top level no longer needs its own erase counter.

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- WIDTH, 160: screen width in pixels.
- HEIGHT, 120: screen height in pixels.
- BG_COLOUR, 3'b000: colour written by the clear engine.

Ports:
- CLOCK_50  in  1: system clock; all state updates on the rising edge.
- resetn  in  1: reset, synchronous, active-low.
- pix_valid  in  1: pixel write request.
- pix_ready  out  1: block can accept a pixel this cycle.
- pix_x  in  8: pixel column.
- pix_y  in  7: pixel row.
- pix_colour  in  3: pixel colour.
- clear_req  in  1: start a full-screen clear; level-sampled.
- clear_busy  out  1: clear pending or in progress.
- fb_addr  out  15: framebuffer write address.
- fb_data  out  3: framebuffer write data.
- fb_we  out  1: framebuffer write strobe.
- drop_count  out  8: off-screen pixels discarded; saturating.
- fifo_level  out  4: current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (resetn low at a rising edge):
  - state = IDLE, FIFO emptied, fifo_level = 0.
  - fb_we = 0, fb_addr = 0, fb_data = 0.
  - drop_count = 0, clear_busy = 0, clear address counter = 0.
  - pix_ready = 0 during the reset cycle.
  - Reset mid-clear or mid-drain abandons all work; nothing is written afterwards.
- Handshake:
  - pix_ready = (state == IDLE) && (fifo_level < DEPTH).
  - Push occurs when pix_valid && pix_ready.
  - pix_x, pix_y and pix_colour are ignored when no push occurs.
- FIFO:
  - Order-preserving circular buffer; each entry holds {x, y, colour}.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - A push while full is impossible because pix_ready is low.
- Drain:
  - In IDLE and CLR_DRAIN, if fifo_level > 0, pop one entry per cycle.
  - Outputs are registered at the same edge as the pop: fb_addr = y*WIDTH + x, fb_data = colour, fb_we = 1.
  - Latency: a pixel pushed at edge N into an empty FIFO drives fb_we = 1 after edge N+1.
  - Throughput is one pixel per cycle, sustained.
- Range check:
  - An entry with x >= WIDTH or y >= HEIGHT is popped normally, but fb_we stays 0 for that cycle.
  - drop_count increments by 1 and saturates at 255.
- Address arithmetic:
  - Computed in 15 bits: y*160 = (y<<7) + (y<<5).
  - Maximum legal address is 19199; no overflow.
- State machine:
  - IDLE: if clear_req, go to CLR_DRAIN. A pixel pushed in the same cycle is retained and drained first.
  - CLR_DRAIN: pix_ready = 0; keep draining. When fifo_level == 0 after the current pop, go to CLR_RUN.
  - CLR_RUN: each cycle drive fb_we = 1, fb_addr = counter, fb_data = BG_COLOUR, then counter++. When counter == WIDTH*HEIGHT-1 has been written, return to IDLE and reset counter to 0.
- clear_busy = 1 in CLR_DRAIN and CLR_RUN, 0 in IDLE.
- clear_req is ignored while clear_busy is 1; no queuing.
- Clear duration from an empty FIFO: exactly WIDTH*HEIGHT write cycles plus 1 transition cycle.
- fb_we is 0 in any cycle with no pop and no clear write. fb_addr and fb_data hold their last value.

Test Plan:
- Reset, then push (x=5, y=3, c=3'b101) with FIFO empty -> fb_we=1 exactly two edges after the push; fb_addr=485, fb_data=5, fifo_level back to 0.
- Push 12 consecutive pixels, pix_valid held high, DEPTH=8 -> all 12 written in order with no loss; fifo_level never exceeds 8.
- Push x=160,y=0, then x=0,y=120, then x=159,y=119 -> only the third is written (fb_addr=19199); drop_count=2. Pre-load drop_count with 300 off-screen pushes -> drop_count holds at 255.
- With 3 entries queued, pulse clear_req -> pix_ready=0 immediately; the 3 entries are written first; then 19200 writes of BG_COLOUR at addresses 0..19199; clear_busy falls after the final write; pix_ready rises.
- Assert clear_req again during CLR_RUN -> no restart; total clear writes remain 19200.
- Assert resetn=0 at clear address 1000 -> next cycle fb_we=0, clear_busy=0, fifo_level=0; subsequent pixel push is written with normal 2-edge latency.

Source files
------------

// File: rtl/pixel_frame_writer.sv
// Pixel stream to framebuffer write port: small FIFO, off-screen filtering with
// a saturating drop counter, and a full-screen clear engine.
module pixel_frame_writer #(
  parameter int          DEPTH     = 8,
  parameter int          WIDTH     = 160,
  parameter int          HEIGHT    = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_x,
  input  logic [6:0]  pix_y,
  input  logic [2:0]  pix_colour,
  input  logic        clear_req,
  output logic        clear_busy,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_we,
  output logic [7:0]  drop_count,
  output logic [3:0]  fifo_level
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  DEPTH_L  = 4'(DEPTH);
  localparam logic [7:0]  WIDTH_L  = 8'(WIDTH);
  localparam logic [6:0]  HEIGHT_L = 7'(HEIGHT);
  localparam logic [14:0] LAST_PIX = 15'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, CLR_DRAIN, CLR_RUN} state_t;

  state_t          state;
  logic [17:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [14:0]     clr_cnt;
  logic            push;
  logic            pop;
  logic [7:0]      head_x;
  logic [6:0]      head_y;
  logic [2:0]      head_c;
  logic            head_on_screen;
  logic [14:0]     head_addr;

  assign pix_ready  = resetn && (state == IDLE) && (fifo_level < DEPTH_L);
  assign clear_busy = (state != IDLE);
  assign push       = pix_valid && pix_ready;
  assign pop        = (state != CLR_RUN) && (fifo_level != 4'd0);

  assign {head_x, head_y, head_c} = mem[rd_ptr];
  assign head_on_screen = (head_x < WIDTH_L) && (head_y < HEIGHT_L);
  // y*160 as (y<<7) + (y<<5), kept within 15 bits
  assign head_addr = {1'b0, head_y, 7'b0} + {3'b0, head_y, 5'b0} + {7'b0, head_x};

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= {pix_x, pix_y, pix_colour};
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= 4'd0;
      clr_cnt    <= 15'd0;
      fb_we      <= 1'b0;
      fb_addr    <= 15'd0;
      fb_data    <= 3'd0;
      drop_count <= 8'd0;
    end else begin
      fb_we <= 1'b0;

      if (push) wr_ptr <= wr_ptr + 1'b1;

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (head_on_screen) begin
          fb_we   <= 1'b1;
          fb_addr <= head_addr;
          fb_data <= head_c;
        end else if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 4'd1;
        2'b01:   fifo_level <= fifo_level - 4'd1;
        default: fifo_level <= fifo_level;
      endcase

      case (state)
        IDLE: begin
          if (clear_req) state <= CLR_DRAIN;
        end
        CLR_DRAIN: begin
          // no pushes here, so at most one entry left means empty after this pop
          if (fifo_level <= 4'd1) state <= CLR_RUN;
        end
        CLR_RUN: begin
          fb_we   <= 1'b1;
          fb_addr <= clr_cnt;
          fb_data <= BG_COLOUR;
          if (clr_cnt == LAST_PIX) begin
            clr_cnt <= 15'd0;
            state   <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + 15'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench for pixel_frame_writer: latency, streaming, off-screen drops,
// clear engine and reset during a clear.
module tb_pixel_frame_writer;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  pix_x = 8'd0;
  logic [6:0]  pix_y = 7'd0;
  logic [2:0]  pix_colour = 3'd0;
  logic        clear_req = 1'b0;
  logic        clear_busy;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic [7:0]  drop_count;
  logic [3:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  pixel_frame_writer #(.DEPTH(8), .WIDTH(160), .HEIGHT(120), .BG_COLOUR(3'b000)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; pix_valid = 1'b0; clear_req = 1'b0;
    tick; tick;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we: got %0d expected 0", fb_we); end
    checks++; if (fb_addr !== 15'd0) begin errors++; $display("FAIL reset_fb_addr: got %0d expected 0", fb_addr); end
    checks++; if (fb_data !== 3'd0) begin errors++; $display("FAIL reset_fb_data: got %0d expected 0", fb_data); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", clear_busy); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %0d expected 0", pix_ready); end
    resetn = 1'b1;
    tick;
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %0d expected 1", pix_ready); end
  endtask

  task automatic test_latency;
    pix_x = 8'd5; pix_y = 7'd3; pix_colour = 3'b101; pix_valid = 1'b1;
    tick;
    pix_valid = 1'b0;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL lat_early_we: got %0d expected 0", fb_we); end
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL lat_level1: got %0d expected 1", fifo_level); end
    tick;
    checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL lat_we: got %0d expected 1", fb_we); end
    checks++; if (fb_addr !== 15'd485) begin errors++; $display("FAIL lat_addr: got %0d expected 485", fb_addr); end
    checks++; if (fb_data !== 3'd5) begin errors++; $display("FAIL lat_data: got %0d expected 5", fb_data); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL lat_level0: got %0d expected 0", fifo_level); end
    tick;
    checks++; if (fb_we !== 1'b0 || fb_addr !== 15'd485) begin errors++; $display("FAIL lat_hold: got we=%0d addr=%0d expected we=0 addr=485", fb_we, fb_addr); end
  endtask

  task automatic test_back_to_back;
    int pushed = 0, written = 0, maxlvl = 0, nmis = 0;
    int ex, ey, ea, bad_got, bad_exp;
    logic did;
    for (int cyc = 0; cyc < 40 && written < 12; cyc++) begin
      if (pushed < 12) begin
        pix_valid = 1'b1; pix_x = 8'(pushed * 13 + 2); pix_y = 7'(pushed * 9 + 1); pix_colour = 3'(pushed + 1);
      end else pix_valid = 1'b0;
      did = pix_valid && pix_ready;
      tick;
      if (did) pushed++;
      if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
      if (fb_we) begin
        ex = written * 13 + 2; ey = written * 9 + 1; ea = ey * 160 + ex;
        if (fb_addr !== 15'(ea) || fb_data !== 3'(written + 1)) begin
          if (nmis == 0) begin bad_got = int'(fb_addr); bad_exp = ea; end
          nmis++;
        end
        written++;
      end
    end
    pix_valid = 1'b0;
    checks++; if (written != 12) begin errors++; $display("FAIL b2b_count: got %0d expected 12", written); end
    checks++; if (nmis != 0) begin errors++; $display("FAIL b2b_order: got addr %0d expected %0d (%0d bad)", bad_got, bad_exp, nmis); end
    checks++; if (maxlvl > 8) begin errors++; $display("FAIL b2b_level: got %0d expected <=8", maxlvl); end
  endtask

  task automatic test_offscreen;
    logic [7:0] tx [3];
    logic [6:0] ty [3];
    int writes = 0, stray = 0;
    logic [14:0] last_addr = '0;
    logic [2:0]  last_data = '0;
    tx[0] = 8'd160; tx[1] = 8'd0;   tx[2] = 8'd159;
    ty[0] = 7'd0;   ty[1] = 7'd120; ty[2] = 7'd119;
    for (int k = 0; k < 6; k++) begin
      pix_valid = (k < 3);
      if (k < 3) begin pix_x = tx[k]; pix_y = ty[k]; pix_colour = 3'(k + 1); end
      tick;
      if (fb_we) begin writes++; last_addr = fb_addr; last_data = fb_data; end
    end
    checks++; if (writes != 1) begin errors++; $display("FAIL off_writes: got %0d expected 1", writes); end
    checks++; if (last_addr !== 15'd19199) begin errors++; $display("FAIL off_addr: got %0d expected 19199", last_addr); end
    checks++; if (last_data !== 3'd3) begin errors++; $display("FAIL off_data: got %0d expected 3", last_data); end
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL off_drop2: got %0d expected 2", drop_count); end
    for (int k = 0; k < 300; k++) begin
      pix_valid = 1'b1; pix_x = 8'd200; pix_y = 7'd5; pix_colour = 3'd7;
      tick;
      if (fb_we) stray++;
    end
    pix_valid = 1'b0;
    tick; tick;
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d expected 255", drop_count); end
    checks++; if (stray != 0) begin errors++; $display("FAIL drop_no_write: got %0d expected 0", stray); end
  endtask

  task automatic test_clear;
    int e = 0, nmis = 0, done_cyc = -1, extra = 0, bad_e = 0, bad_got = 0;
    logic done = 1'b0;
    int px [3], py [3], pc [3];
    px[0] = 10; py[0] = 0; pc[0] = 1;
    px[1] = 20; py[1] = 1; pc[1] = 2;
    px[2] = 30; py[2] = 2; pc[2] = 3;
    for (int cyc = 0; cyc < 19400 && !done; cyc++) begin
      if (cyc < 3) begin
        pix_valid = 1'b1; pix_x = 8'(px[cyc]); pix_y = 7'(py[cyc]); pix_colour = 3'(pc[cyc]);
      end else pix_valid = 1'b0;
      clear_req = (cyc == 2) || (e >= 503 && e < 510);
      tick;
      if (cyc == 2) begin
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL clr_ready_low: got %0d expected 0", pix_ready); end
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL clr_busy_high: got %0d expected 1", clear_busy); end
      end
      if (fb_we) begin
        if (e < 3) begin
          if (fb_addr !== 15'(py[e] * 160 + px[e]) || fb_data !== 3'(pc[e])) begin
            if (nmis == 0) begin bad_e = e; bad_got = int'(fb_addr); end
            nmis++;
          end
        end else if (fb_addr !== 15'(e - 3) || fb_data !== 3'b000) begin
          if (nmis == 0) begin bad_e = e; bad_got = int'(fb_addr); end
          nmis++;
        end
        e++;
        if (e == 19203) begin
          done = 1'b1; done_cyc = cyc;
          checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL clr_busy_fall: got %0d expected 0", clear_busy); end
          checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL clr_ready_rise: got %0d expected 1", pix_ready); end
        end
      end
    end
    clear_req = 1'b0; pix_valid = 1'b0;
    checks++; if (e != 19203) begin errors++; $display("FAIL clr_total: got %0d expected 19203", e); end
    checks++; if (nmis != 0) begin errors++; $display("FAIL clr_seq: write %0d got addr %0d (%0d bad)", bad_e, bad_got, nmis); end
    checks++; if (done_cyc != 19203) begin errors++; $display("FAIL clr_duration: got %0d expected 19203", done_cyc); end
    repeat (5) begin tick; if (fb_we) extra++; end
    checks++; if (extra != 0 || clear_busy !== 1'b0) begin errors++; $display("FAIL clr_no_restart: got %0d writes busy=%0d expected 0", extra, clear_busy); end
  endtask

  task automatic test_reset_mid_clear;
    logic found = 1'b0;
    int stray = 0;
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      tick;
      if (fb_we && fb_addr == 15'd1000) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_reach_1000: got 0 expected 1"); end
    resetn = 1'b0;
    tick;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0d expected 0", fb_we); end
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0d expected 0", clear_busy); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
    resetn = 1'b1;
    repeat (5) begin tick; if (fb_we) stray++; end
    checks++; if (stray != 0) begin errors++; $display("FAIL rst_abandon: got %0d writes expected 0", stray); end
    pix_x = 8'd10; pix_y = 7'd20; pix_colour = 3'd6; pix_valid = 1'b1;
    tick;
    pix_valid = 1'b0;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rst_push_early: got %0d expected 0", fb_we); end
    tick;
    checks++; if (fb_we !== 1'b1 || fb_addr !== 15'd3210 || fb_data !== 3'd6) begin
      errors++; $display("FAIL rst_push_write: got we=%0d addr=%0d data=%0d expected we=1 addr=3210 data=6", fb_we, fb_addr, fb_data);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_back_to_back;
    test_offscreen;
    test_clear;
    test_reset_mid_clear;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
